// File: rtl/nb_ul_scrambler.sv
// nb_ul_scrambler: NB-IoT NPUSCH bit-level scrambler.
// Each accepted input bit is XORed with the length-31 Gold sequence c(n), seeded from c_init.
// The sequence is warmed up by NC advances before c(0) is used.
// Optional build macro SCRAMBLER_BYPASS_EN adds a 'bypass' input. When bypass is high, bits pass
// through unscrambled, but the LFSRs and the bit counter keep stepping so that alignment is kept.
module nb_ul_scrambler #(
  parameter int NC     = 1600,
  parameter int N_BITS = 2880,
  parameter int CNT_W  = 12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [30:0] c_init,
  input  logic        start,
  input  logic        in_bit,
  input  logic        in_en,
`ifdef SCRAMBLER_BYPASS_EN
  input  logic        bypass,
`else
`endif
  output logic        in_rdy,
  output logic        out_bit,
  output logic        out_en,
  output logic        busy,
  output logic        done,
  output logic        drop_err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WARMUP = 2'd1,
    RUN    = 2'd2
  } state_t;

  // Terminal counter values; NC_LAST is only reached when NC > 0.
  localparam logic [CNT_W-1:0] NC_LAST   = CNT_W'(NC - 1);
  localparam logic [CNT_W-1:0] BITS_LAST = CNT_W'(N_BITS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_t            state_q, state_d;
  logic [30:0]       x1_q, x1_d;
  logic [30:0]       x2_q, x2_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              outBit_q, outBit_d;
  logic              outEn_q, outEn_d;
  logic              done_q, done_d;
  logic              dropErr_q, dropErr_d;
  logic              goldBit;
  logic              scrBit;

  // x1 recursion: x1(n+31) = x1(n+3) ^ x1(n); bit0 of the register holds x1(n).
  function automatic logic [30:0] advX1(input logic [30:0] x);
    return {x[3] ^ x[0], x[30:1]};
  endfunction

  // x2 recursion: x2(n+31) = x2(n+3) ^ x2(n+2) ^ x2(n+1) ^ x2(n).
  function automatic logic [30:0] advX2(input logic [30:0] x);
    return {x[3] ^ x[2] ^ x[1] ^ x[0], x[30:1]};
  endfunction

  assign goldBit = x1_q[0] ^ x2_q[0];

`ifdef SCRAMBLER_BYPASS_EN
  assign scrBit = bypass ? in_bit : (in_bit ^ goldBit);
`else
  assign scrBit = in_bit ^ goldBit;
`endif

  // Next-state logic: start/warm-up sequencing, per-accept scrambling and the sticky drop flag.
  always_comb begin
    state_d   = state_q;
    x1_d      = x1_q;
    x2_d      = x2_q;
    cnt_d     = cnt_q;
    outBit_d  = outBit_q;
    outEn_d   = 1'b0;
    done_d    = 1'b0;
    dropErr_d = dropErr_q;

    if (in_en && (state_q != RUN)) begin
      dropErr_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          x1_d      = 31'h1;
          x2_d      = c_init;
          cnt_d     = '0;
          dropErr_d = 1'b0;
          state_d   = (NC == 0) ? RUN : WARMUP;
        end
      end

      WARMUP: begin
        x1_d = advX1(x1_q);
        x2_d = advX2(x2_q);
        if (cnt_q == NC_LAST) begin
          cnt_d   = '0;
          state_d = RUN;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      RUN: begin
        if (in_en) begin
          outBit_d = scrBit;
          outEn_d  = 1'b1;
          x1_d     = advX1(x1_q);
          x2_d     = advX2(x2_q);
          if (cnt_q == BITS_LAST) begin
            done_d  = 1'b1;
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any codeword in flight immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      x1_q      <= '0;
      x2_q      <= '0;
      cnt_q     <= '0;
      outBit_q  <= 1'b0;
      outEn_q   <= 1'b0;
      done_q    <= 1'b0;
      dropErr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      x1_q      <= x1_d;
      x2_q      <= x2_d;
      cnt_q     <= cnt_d;
      outBit_q  <= outBit_d;
      outEn_q   <= outEn_d;
      done_q    <= done_d;
      dropErr_q <= dropErr_d;
    end
  end

  assign in_rdy   = (state_q == RUN);
  assign busy     = (state_q != IDLE);
  assign out_bit  = outBit_q;
  assign out_en   = outEn_q;
  assign done     = done_q;
  assign drop_err = dropErr_q;

endmodule

// File: tb/tb_nb_ul_scrambler.sv
// tb_nb_ul_scrambler: scoreboard bench for nb_ul_scrambler.
// Instance A runs with no warm-up and a 32-bit codeword; instance B uses the default parameters.
// Expected bits come from an array-based Gold sequence model built from the recursion definition.
module tb_nb_ul_scrambler;

  logic        clk = 1'b0;
  logic        reset;
  logic        startA, startB;
  logic        inBit, inEn;
  logic [30:0] cInit;
  logic        sel;

  logic rdyA, outBitA, outEnA, busyA, doneA, dropErrA;
  logic rdyB, outBitB, outEnB, busyB, doneB, dropErrB;

  logic selRdy, selOutBit, selOutEn, selBusy, selDone, selDropErr, otherOutEn;

  int errors = 0;
  int checks = 0;
  int goldIdx, goldLen;
  int outEnCount, doneCount;

  logic [1:0] sbQ[$];
  bit         goldC[0:4095];
  bit         inHist[0:4095];
  bit         x1a[0:4607];
  bit         x2a[0:4607];

  always #5 clk = ~clk;

  nb_ul_scrambler #(.NC(0), .N_BITS(32), .CNT_W(12)) dutA (
    .clk(clk), .reset(reset), .c_init(cInit), .start(startA),
    .in_bit(inBit), .in_en(inEn),
    .in_rdy(rdyA), .out_bit(outBitA), .out_en(outEnA),
    .busy(busyA), .done(doneA), .drop_err(dropErrA)
  );

  nb_ul_scrambler dutB (
    .clk(clk), .reset(reset), .c_init(cInit), .start(startB),
    .in_bit(inBit), .in_en(inEn),
    .in_rdy(rdyB), .out_bit(outBitB), .out_en(outEnB),
    .busy(busyB), .done(doneB), .drop_err(dropErrB)
  );

  assign selRdy     = sel ? rdyB     : rdyA;
  assign selOutBit  = sel ? outBitB  : outBitA;
  assign selOutEn   = sel ? outEnB   : outEnA;
  assign selBusy    = sel ? busyB    : busyA;
  assign selDone    = sel ? doneB    : doneA;
  assign selDropErr = sel ? dropErrB : dropErrA;
  assign otherOutEn = sel ? outEnA   : outEnB;

  // Single comparison point: counts every check and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Gold sequence from the sequence-domain recursion: c(n) = x1(n+nc) ^ x2(n+nc).
  task automatic buildGold(input logic [30:0] ci, input int nc, input int len);
    for (int i = 0; i < 31; i++) begin
      x1a[i] = (i == 0);
      x2a[i] = ci[i];
    end
    for (int n = 0; n + 31 < nc + len; n++) begin
      x1a[n+31] = x1a[n+3] ^ x1a[n];
      x2a[n+31] = x2a[n+3] ^ x2a[n+2] ^ x2a[n+1] ^ x2a[n];
    end
    for (int n = 0; n < len; n++) begin
      goldC[n] = x1a[n+nc] ^ x2a[n+nc];
    end
    goldLen = len;
  endtask

  // Pulse start on the selected instance and confirm it was taken.
  task automatic startCodeword(input logic [30:0] ci);
    @(negedge clk);
    cInit = ci;
    if (sel) startB = 1'b1; else startA = 1'b1;
    @(negedge clk);
    startA  = 1'b0;
    startB  = 1'b0;
    goldIdx = 0;
    checkOutput("busy_after_start", selBusy, 1);
    checkOutput("drop_err_after_start", selDropErr, 0);
  endtask

  // Wait (bounded) for the selected instance to open its input.
  task automatic waitReady(input int budget);
    int n = 0;
    while (!selRdy && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput("ready_reached", selRdy, 1);
  endtask

  // Feed bits with optional random gaps. Mode 0 zeros, 1 ones, 2 random (recorded), 3 replay.
  task automatic applyStimulus(input int count, input int mode, input int gapPct);
    int sent   = 0;
    int cycles = 0;
    bit b;
    while (sent < count && cycles < count * 8 + 100) begin
      @(negedge clk);
      cycles++;
      if (int'($urandom_range(99)) < gapPct) begin
        inEn = 1'b0;
      end else begin
        case (mode)
          0:       b = 1'b0;
          1:       b = 1'b1;
          2:       b = 1'($urandom_range(1));
          default: b = inHist[goldIdx];
        endcase
        inBit = b;
        inEn  = 1'b1;
        if (selRdy) begin
          sbQ.push_back({goldIdx == goldLen - 1, b ^ goldC[goldIdx]});
          if (mode == 2) inHist[goldIdx] = b;
          goldIdx++;
          sent++;
        end
      end
    end
    @(negedge clk);
    inEn = 1'b0;
    checkOutput("feed_complete", sent, count);
  endtask

  // Output monitor: pops the scoreboard on every out_en of the selected instance.
  always @(negedge clk) begin
    logic [1:0] e;
    if (!reset) begin
      checkOutput("stray_out_en", otherOutEn, 0);
      checkOutput("done_gated", selDone & ~selOutEn, 0);
      if (selOutEn) begin
        outEnCount++;
        if (selDone) doneCount++;
        checkOutput("sb_has_entry", sbQ.size() != 0, 1);
        if (sbQ.size() != 0) begin
          e = sbQ.pop_front();
          checkOutput("out_bit", selOutBit, e[0]);
          checkOutput("done", selDone, e[1]);
        end
      end
    end
  end

  initial begin
    logic [30:0] ci;
    reset  = 1'b1;
    startA = 1'b0;
    startB = 1'b0;
    inBit  = 1'b0;
    inEn   = 1'b0;
    cInit  = '0;
    sel    = 1'b0;
    goldIdx = 0;
    goldLen = 0;
    outEnCount = 0;
    doneCount  = 0;

    repeat (3) @(negedge clk);
    checkOutput("rst_busyA", busyA, 0);
    checkOutput("rst_rdyA", rdyA, 0);
    checkOutput("rst_outEnA", outEnA, 0);
    checkOutput("rst_outBitA", outBitA, 0);
    checkOutput("rst_doneA", doneA, 0);
    checkOutput("rst_dropErrA", dropErrA, 0);
    checkOutput("rst_busyB", busyB, 0);
    checkOutput("rst_rdyB", rdyB, 0);
    checkOutput("rst_outEnB", outEnB, 0);
    checkOutput("rst_outBitB", outBitB, 0);
    checkOutput("rst_doneB", doneB, 0);
    checkOutput("rst_dropErrB", dropErrB, 0);
    reset = 1'b0;

    // T1: no warm-up, c_init=0, 32 zero bits
    sel = 1'b0;
    buildGold(31'h0, 0, 32);
    outEnCount = 0;
    doneCount  = 0;
    startCodeword(31'h0);
    applyStimulus(32, 0, 0);
    @(negedge clk); #1;
    checkOutput("t1_out_en_count", outEnCount, 32);
    checkOutput("t1_done_count", doneCount, 1);
    checkOutput("t1_busy_after", selBusy, 0);

    // T2: no warm-up, c_init=1, 32 one bits
    buildGold(31'h1, 0, 32);
    outEnCount = 0;
    doneCount  = 0;
    startCodeword(31'h1);
    applyStimulus(32, 1, 0);
    @(negedge clk); #1;
    checkOutput("t2_out_en_count", outEnCount, 32);
    checkOutput("t2_done_count", doneCount, 1);
    checkOutput("t2_rdy_after", selRdy, 0);

    // T3/T4: default warm-up timing with a dropped pulse inside warm-up
    sel = 1'b1;
    ci  = 31'($urandom());
    buildGold(ci, 1600, 2880);
    outEnCount = 0;
    doneCount  = 0;
    @(negedge clk);
    cInit  = ci;
    startB = 1'b1;
    @(posedge clk); #1;
    startB  = 1'b0;
    goldIdx = 0;
    checkOutput("t3_busy_cycle1", selBusy, 1);
    checkOutput("t3_rdy_cycle1", selRdy, 0);
    checkOutput("t3_drop_err_start", selDropErr, 0);
    for (int k = 2; k <= 1601; k++) begin
      @(posedge clk); #1;
      checkOutput("t3_in_rdy", selRdy, (k == 1601) ? 32'd1 : 32'd0);
      checkOutput("t3_busy", selBusy, 1);
      if (k == 100) inEn = 1'b1;
      if (k == 101) begin
        checkOutput("t4_drop_err", selDropErr, 1);
        inEn = 1'b0;
      end
    end

    // T5: full codeword with random gaps
    applyStimulus(2880, 2, 30);
    @(negedge clk); #1;
    checkOutput("t5_out_en_count", outEnCount, 2880);
    checkOutput("t5_done_count", doneCount, 1);
    checkOutput("t5_busy_after", selBusy, 0);
    checkOutput("t5_rdy_after", selRdy, 0);
    checkOutput("t4_drop_err_sticky", selDropErr, 1);

    // T6: reset in the middle of RUN, then replay the same start
    outEnCount = 0;
    doneCount  = 0;
    startCodeword(ci);
    waitReady(2000);
    applyStimulus(1000, 3, 30);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("t6_rst_busy", selBusy, 0);
    checkOutput("t6_rst_rdy", selRdy, 0);
    checkOutput("t6_rst_out_en", selOutEn, 0);
    checkOutput("t6_rst_out_bit", selOutBit, 0);
    checkOutput("t6_rst_done", selDone, 0);
    checkOutput("t6_sb_drained", sbQ.size(), 0);
    checkOutput("t6_out_en_count_pre", outEnCount, 1000);
    checkOutput("t6_done_count_pre", doneCount, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    outEnCount = 0;
    startCodeword(ci);
    waitReady(2000);
    applyStimulus(1000, 3, 20);
    @(negedge clk); #1;
    checkOutput("t6_out_en_count", outEnCount, 1000);
    checkOutput("t6_sb_empty", sbQ.size(), 0);
    checkOutput("t6_busy_mid", selBusy, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
